// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall
);

  // Streak counter must be able to hold STARVE_LIMIT itself; the +2 keeps the
  // width non-zero even when STARVE_LIMIT is 0.
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     streak;
  logic [SW-1:0]     streak_nxt;
  logic [TW-1:0]     tcnt;
  logic              owner_d;
  logic              grant_d;
  logic              grant_i;
  logic              done;
  logic              abort;
  logic [DATA_W-1:0] rsp_rdata;

  // Requesters see stall until their own completion pulse.
  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, grant decision and completion detection.
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    rsp_rdata  = '0;
    case (state)
      S_IDLE: begin
        // Data wins unless the fetch side has already lost STARVE_LIMIT
        // contested rounds in a row.
        if (d_req && (!i_req || (streak < SW'(STARVE_LIMIT)))) begin
          grant_d    = 1'b1;
          streak_nxt = i_req ? streak + SW'(1) : '0;
          state_nxt  = S_MEM;
        end else if (i_req) begin
          grant_i    = 1'b1;
          streak_nxt = '0;
          state_nxt  = S_MEM;
        end
      end
      S_MEM: begin
        // A late m_ack on the expiry cycle still counts as success.
        if (m_ack) begin
          done      = 1'b1;
          rsp_rdata = m_we ? '0 : m_rdata;
          state_nxt = S_RESP;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Anti-starvation streak and per-access timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
      tcnt   <= '0;
    end else begin
      streak <= streak_nxt;
      if (grant_d || grant_i) begin
        tcnt <= '0;
      end else if (state == S_MEM && !done && !abort) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  // Memory-side request registers and requester-side response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      owner_d <= 1'b0;
      i_ack   <= 1'b0;
      i_rdata <= '0;
      i_err   <= 1'b0;
      d_ack   <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (grant_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        owner_d <= 1'b1;
      end else if (grant_i) begin
        m_req   <= 1'b1;
        m_we    <= 1'b0;
        m_addr  <= i_addr;
        m_wdata <= '0;
        owner_d <= 1'b0;
      end
      if (done || abort) begin
        m_req <= 1'b0;
        if (owner_d) begin
          d_ack   <= 1'b1;
          d_rdata <= rsp_rdata;
          d_err   <= abort;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= rsp_rdata;
          i_err   <= abort;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        stall;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  grant_t g_q[$];
  rsp_t   i_q[$];
  rsp_t   d_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: acks on the mem_lat-th cycle of m_req, or never.
  int mem_lat   = 1;
  bit mem_never = 1'b0;
  int req_cnt   = 0;
  int last_len  = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C22_0004 : (a ^ 32'h5A5A_0000);
  endfunction

  always @(posedge clk) begin
    #1;
    if (m_req) begin
      req_cnt++;
    end else begin
      if (req_cnt != 0) last_len = req_cnt;
      req_cnt = 0;
    end
    m_ack   = m_req && !mem_never && (req_cnt == mem_lat);
    m_rdata = m_req ? mem_rd(m_addr) : 32'h0;
  end

  // Monitor: compares each new memory access and each ack against the queues.
  logic m_req_q = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (m_req && !m_req_q) begin
        if (g_q.size() == 0) begin
          check("grant_unexpected", 1, 0);
        end else begin
          grant_t g;
          g = g_q.pop_front();
          check("grant_we", m_we, g.we);
          check("grant_addr", m_addr, g.addr);
          check("grant_wdata", m_wdata, g.wdata);
        end
      end
      if (i_ack || d_ack) check("ack_exclusive", i_ack & d_ack, 0);
      if (i_ack) begin
        if (i_q.size() == 0) begin
          check("i_ack_unexpected", 1, 0);
        end else begin
          rsp_t r;
          r = i_q.pop_front();
          check("i_rdata", i_rdata, r.rdata);
          check("i_err", i_err, r.err);
        end
      end
      if (d_ack) begin
        if (d_q.size() == 0) begin
          check("d_ack_unexpected", 1, 0);
        end else begin
          rsp_t r;
          r = d_q.pop_front();
          check("d_rdata", d_rdata, r.rdata);
          check("d_err", d_err, r.err);
        end
      end
    end
    m_req_q = m_req;
  end

  task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err, input bit chk_stall);
    int n;
    d_q.push_back('{rdata: exp_rdata, err: exp_err});
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (chk_stall && !d_ack) check("d_stall_wait", stall, 1);
    end while (!d_ack && n < 100);
    if (!d_ack) check("d_ack_timeout", 0, 1);
    if (chk_stall) check("d_stall_done", stall, 0);
    d_req = 1'b0;
  endtask

  task automatic issue_i(input logic [31:0] a, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit chk_stall);
    int n;
    i_q.push_back('{rdata: exp_rdata, err: exp_err});
    i_req = 1'b1; i_addr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (chk_stall && !i_ack) check("i_stall_wait", stall, 1);
    end while (!i_ack && n < 100);
    if (!i_ack) check("i_ack_timeout", 0, 1);
    if (chk_stall) check("i_stall_done", stall, 0);
    i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    m_ack = 1'b0; m_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_m_req", m_req, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    check("rst_errs", {i_err, d_err}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    check("rst_m_bus", {m_we, m_addr, m_wdata}, 0);
    check("rst_stall", stall, 0);
    rst = 1'b1;
    @(negedge clk);

    // Lone fetch; idle data port carries junk that must not leak into m_*.
    d_we = 1'b1; d_wdata = 32'hFFFF_FFFF;
    g_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    issue_i(32'h40, 32'h8C22_0004, 1'b0, 1'b1);
    @(negedge clk);

    // Store: read data forced to zero.
    g_q.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hDEAD_BEEF});
    issue_d(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    @(negedge clk);

    // Contention: expected order D,D,D,D,I,D,D,D,D,I.
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        g_q.push_back('{we: 1'b0, addr: 32'h1000 + ((k == 4) ? 32'h0 : 32'h4), wdata: 32'h0});
      end else begin
        int dk;
        dk = (k < 4) ? k : k - 1;
        g_q.push_back('{we: dk[0], addr: 32'h200 + 32'(4 * dk), wdata: 32'h1111_0000 + 32'(dk)});
      end
    end
    fork
      begin
        for (int dk = 0; dk < 8; dk++) begin
          logic [31:0] a;
          a = 32'h200 + 32'(4 * dk);
          issue_d(dk[0], a, 32'h1111_0000 + 32'(dk), dk[0] ? 32'h0 : mem_rd(a), 1'b0, 1'b0);
        end
      end
      begin
        for (int ik = 0; ik < 2; ik++) begin
          logic [31:0] a;
          a = 32'h1000 + 32'(4 * ik);
          issue_i(a, mem_rd(a), 1'b0, 1'b0);
        end
      end
    join
    @(negedge clk);

    // Timeout: no ack ever, 15 request cycles then error response.
    mem_never = 1'b1;
    g_q.push_back('{we: 1'b0, addr: 32'h180, wdata: 32'h0});
    issue_d(1'b0, 32'h180, 32'h0, 32'h0, 1'b1, 1'b1);
    check("timeout_len", last_len, 15);
    mem_never = 1'b0;
    @(negedge clk);
    g_q.push_back('{we: 1'b0, addr: 32'h184, wdata: 32'h0});
    issue_d(1'b0, 32'h184, 32'h0, mem_rd(32'h184), 1'b0, 1'b1);
    @(negedge clk);

    // Ack on the expiry cycle wins over the timeout.
    mem_lat = 15;
    g_q.push_back('{we: 1'b0, addr: 32'h188, wdata: 32'h0});
    issue_d(1'b0, 32'h188, 32'h0, mem_rd(32'h188), 1'b0, 1'b1);
    check("edge_len", last_len, 15);
    mem_lat = 1;
    @(negedge clk);

    // Reset while an access is outstanding in MEM.
    mem_never = 1'b1;
    g_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0;
    i_req = 1'b1; i_addr = 32'h2000;
    repeat (4) @(negedge clk);
    check("pre_rst_m_req", m_req, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_m_req", m_req, 0);
    check("mid_rst_acks", {i_ack, d_ack}, 0);
    i_req = 1'b0; d_req = 1'b0;
    mem_never = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    g_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    g_q.push_back('{we: 1'b0, addr: 32'h2000, wdata: 32'h0});
    fork
      issue_d(1'b0, 32'h300, 32'h0, mem_rd(32'h300), 1'b0, 1'b0);
      issue_i(32'h2000, mem_rd(32'h2000), 1'b0, 1'b0);
    join
    repeat (3) @(negedge clk);

    check("scoreboard_drain", g_q.size() + i_q.size() + d_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
